fpu_sqrt_rec: RTL
=================

// Module: fpu_sqrt_rec
// PURPOSE
//  Parametrised IEEE-754 square-root unit for the FPU arithmetic datapath (op_sqrt).
//  Computes a digit-recurrence (restoring, radix-2) square root, one root bit per cycle.
//  Rounds round-to-nearest-even and reports invalid/inexact flags.
//  Sits under the arith FSM; uses the same start/done level handshake as the FPU main FSM.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MAN_W   23   stored fraction width; W = 1+EXP_W+MAN_W (default 32, binary32)
//  QNAN    {1'b0,{EXP_W{1'b1}},1'b1,{MAN_W-1{1'b0}}}   canonical quiet NaN returned on invalid
// PORTS
//  clk      in   1   clock, all state on rising edge
//  rst      in   1   synchronous, active-high reset
//  start    in   1   level request; sampled only in IDLE
//  a        in   W   operand; captured in the cycle start is accepted
//  result   out  W   root; valid while done=1
//  done     out  1   high in RESULT_VALID only
//  busy     out  1   high in every state except IDLE
//  invalid  out  1   IEEE invalid flag, valid with done
//  inexact  out  1   IEEE inexact flag, valid with done
// BEHAVIOUR
//  Reset: FSM->IDLE; result=0, done=0, busy=0, invalid=0, inexact=0. rst wins over start,
//   aborts any operation mid-flight, no partial result is ever presented.
//  FSM (e_fsqrt_st): IDLE -> CHECK_EXC (start=1; a latched) -> EXCEPTIONAL | LOAD ->
//   ITER (MAN_W+2 cycles, counter down to 0) -> ROUND -> RESULT_VALID; EXCEPTIONAL -> RESULT_VALID.
//   RESULT_VALID holds result/flags/done until start sampled 0, then IDLE next cycle.
//   start changes while busy are ignored; a new op needs start low then high again.
//  Latency (start accepted = cycle 0): normal done at cycle MAN_W+6 (29 for default);
//   exceptional done at cycle 3.
//  Exceptional classes (CHECK_EXC): exp==0 (zero or denormal) -> +/-0 with sign of a,
//   denormals flushed, inexact=0; sign=1 and nonzero non-NaN -> QNAN, invalid=1;
//   +inf -> +inf; any NaN -> QNAN, invalid=1 only for signalling NaN (frac MSB=0).
//  LOAD: unbiased E = e - BIAS (BIAS=2^(EXP_W-1)-1), signed EXP_W+1 bits. Significand
//   m=1.f (MAN_W+1 bits). If E odd: m<<=1, E-=1. Radicand = m aligned to 2*(MAN_W+2) bits
//   so the integer root has MAN_W+2 bits (1 int, MAN_W frac, 1 guard).
//   Result exponent = (E>>>1) + BIAS; always in range, no over/underflow possible.
//  ITER: each cycle bring down 2 radicand bits, trial = (rem<<2|bits) - (root<<2|1);
//   if trial>=0 keep trial, root bit=1 else root bit=0. Remainder width MAN_W+4 bits.
//  ROUND: guard=root[0], sticky=(remainder!=0); round up if guard & (sticky | root[1]).
//   Carry-out of rounding (root reaches 2.0) -> fraction 0, exponent+1.
//   inexact = guard | sticky. Result sign always 0 for finite positive inputs.
//  Root is always in [1,2): no post-normalisation shift required.
// STRUCTURE
//  pa_fpu additions: typedef enum e_fsqrt_st {fsqrt_idle_st, fsqrt_check_exc_st,
//   fsqrt_exceptional_st, fsqrt_load_st, fsqrt_iter_st, fsqrt_round_st,
//   fsqrt_result_valid_st}; exponent bias and QNAN helper functions parametrised on widths.
//  One sub-module: fpu_isqrt_core #(N) - integer restoring sqrt of a 2N-bit radicand,
//   load/step inputs, outputs root[N-1:0], remainder_nz; holds no handshake logic.
//  Top module owns FSM, unpack/classify, exponent path, rounding, flags.
// TESTING
//  a=0x40800000 (4.0) -> result 0x40000000, inexact=0, invalid=0, done at cycle 29.
//  a=0x40000000 (2.0, odd E) -> 0x3FB504F3, inexact=1; a=0x3E800000 (0.25) -> 0x3F000000.
//  a=0xBF800000 -> 0x7FC00000 invalid=1; a=0x7F800000 -> 0x7F800000; a=0x80000000 ->
//   0x80000000; a=0x00000001 (denormal) -> 0x00000000; all done at cycle 3.
//  a=0x7F800001 (sNaN) -> 0x7FC00000 invalid=1; a=0x7FC00000 (qNaN) -> 0x7FC00000 invalid=0.
//  Hold start high 10 cycles after done -> done/result stable; drop start -> busy=0 next cycle;
//   toggle start while busy -> no effect on result or latency.
//  Assert rst at ITER cycle 12 -> next cycle IDLE, all outputs 0; new start for 4.0 gives 0x40000000.
//  Param sweep EXP_W=11/MAN_W=52: a=0x4000000000000000 -> 0x3FF6A09E667F3BCD, done cycle 58;
//   random operands vs. reference model ($sqrt + RNE), bit-exact.

Source files
------------

// File: rtl/fpu_sqrt_rec_pkg.sv
// Shared types and width-parametrised helpers for the digit-recurrence square-root unit.
package fpu_sqrt_rec_pkg;

  typedef enum logic [2:0] {
    fsqrt_idle_st,
    fsqrt_check_exc_st,
    fsqrt_exceptional_st,
    fsqrt_load_st,
    fsqrt_iter_st,
    fsqrt_round_st,
    fsqrt_result_valid_st
  } e_fsqrt_st;

  function automatic int fsqrt_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: exponent all ones, fraction MSB set, positive sign.
  function automatic logic [127:0] fsqrt_qnan(input int exp_w, input int man_w);
    logic [127:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
    q[man_w - 1] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/fpu_isqrt_core.sv
// Restoring radix-2 integer square root of a 2N-bit radicand, one root bit per step.
module fpu_isqrt_core #(
  parameter int N = 25
) (
  input  logic           clk,
  input  logic           load,
  input  logic           step,
  input  logic [2*N-1:0] radicand,
  output logic [N-1:0]   root,
  output logic           remainder_nz
);

  logic [2*N-1:0] rad_q;
  logic [N+1:0]   rem_q;
  logic [N+3:0]   rem_ext;
  logic [N+3:0]   sub;
  logic [N+3:0]   trial;
  logic           keep;

  always_comb begin
    rem_ext = {rem_q, rad_q[2*N-1 -: 2]};
    sub     = {2'b00, root, 2'b01};
    trial   = rem_ext - sub;
    keep    = (rem_ext >= sub);
  end

  // NOTE: pure datapath is not reset; load always initialises it before any step is consumed.
  // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (load) begin
      rad_q <= radicand;
      rem_q <= '0;
      root  <= '0;
    end else if (step) begin
      rad_q <= {rad_q[2*N-3:0], 2'b00};
      rem_q <= (N+2)'(keep ? trial : rem_ext);
      root  <= {root[N-2:0], keep};
    end
  end

  assign remainder_nz = |rem_q;

endmodule

// File: rtl/fpu_sqrt_rec.sv
// IEEE-754 square root with RNE rounding: FSM, operand classification, exponent path and rounding.
module fpu_sqrt_rec
  import fpu_sqrt_rec_pkg::*;
#(
  parameter int                     EXP_W = 8,
  parameter int                     MAN_W = 23,
  parameter logic [EXP_W+MAN_W:0]   QNAN  = (EXP_W+MAN_W+1)'(fsqrt_qnan(EXP_W, MAN_W))
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done,
  output logic                   busy,
  output logic                   invalid,
  output logic                   inexact
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 2;
  localparam int CNT_W = $clog2(N + 1);
  localparam int BIAS  = fsqrt_bias(EXP_W);

  typedef logic signed [EXP_W:0] sexp_t;

  e_fsqrt_st            state, next_state;
  logic [W-1:0]         a_q;
  logic [EXP_W-1:0]     res_exp_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 sign_a, exp_zero, exp_ones, frac_nz, is_exc;
  logic [EXP_W-1:0]     exp_a;
  logic [MAN_W-1:0]     frac_a;
  logic [W-1:0]         exc_result;
  logic                 exc_invalid;

  sexp_t                e_unb, e_adj, e_res;
  logic                 e_odd;
  logic [N-1:0]         m_al;
  logic [2*N-1:0]       radicand;

  logic [N-1:0]         root;
  logic                 remainder_nz;
  logic                 guard, sticky, round_up, carry;
  logic [MAN_W-1:0]     frac_rnd;
  logic [EXP_W-1:0]     exp_rnd;

  assign sign_a   = a_q[W-1];
  assign exp_a    = a_q[W-2:MAN_W];
  assign frac_a   = a_q[MAN_W-1:0];
  assign exp_zero = (exp_a == '0);
  assign exp_ones = &exp_a;
  assign frac_nz  = |frac_a;
  assign is_exc   = exp_zero | exp_ones | sign_a;

  // NaN takes priority over sign; zero/denormal keeps its sign rather than becoming invalid.
  always_comb begin
    exc_result  = a_q;
    exc_invalid = 1'b0;
    if (exp_ones && frac_nz) begin
      exc_result  = QNAN;
      exc_invalid = ~frac_a[MAN_W-1];
    end else if (exp_zero) begin
      exc_result  = {sign_a, {(W-1){1'b0}}};
    end else if (sign_a) begin
      exc_result  = QNAN;
      exc_invalid = 1'b1;
    end
  end

  always_comb begin
    e_unb    = sexp_t'({1'b0, exp_a}) - sexp_t'(BIAS);
    e_odd    = e_unb[0];
    e_adj    = e_unb - sexp_t'(e_odd);
    e_res    = (e_adj >>> 1) + sexp_t'(BIAS);
    m_al     = e_odd ? {1'b1, frac_a, 1'b0} : {1'b0, 1'b1, frac_a};
    radicand = {m_al, {N{1'b0}}};
  end

  fpu_isqrt_core #(.N(N)) u_core (
    .clk          (clk),
    .load         (state == fsqrt_load_st),
    .step         (state == fsqrt_iter_st),
    .radicand     (radicand),
    .root         (root),
    .remainder_nz (remainder_nz)
  );

  // Root lies in [1,2), so a rounding carry can only arise from an all-ones fraction.
  always_comb begin
    guard    = root[0];
    sticky   = remainder_nz;
    round_up = guard & (sticky | root[1]);
    frac_rnd = root[N-2:1] + MAN_W'(round_up);
    carry    = root[N-1] & (&root[N-2:1]) & round_up;
    exp_rnd  = res_exp_q + EXP_W'(carry);
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      fsqrt_idle_st:         if (start) next_state = fsqrt_check_exc_st;
      fsqrt_check_exc_st:    next_state = is_exc ? fsqrt_exceptional_st : fsqrt_load_st;
      fsqrt_exceptional_st:  next_state = fsqrt_result_valid_st;
      fsqrt_load_st:         next_state = fsqrt_iter_st;
      fsqrt_iter_st:         if (cnt_q == '0) next_state = fsqrt_round_st;
      fsqrt_round_st:        next_state = fsqrt_result_valid_st;
      fsqrt_result_valid_st: if (!start) next_state = fsqrt_idle_st;
      default:               next_state = fsqrt_idle_st;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= fsqrt_idle_st;
      result  <= '0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else begin
      state <= next_state;
      if (state == fsqrt_exceptional_st) begin
        result  <= exc_result;
        invalid <= exc_invalid;
        inexact <= 1'b0;
      end else if (state == fsqrt_round_st) begin
        result  <= {1'b0, exp_rnd, frac_rnd};
        invalid <= 1'b0;
        inexact <= guard | sticky;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == fsqrt_idle_st && start) a_q <= a;
    if (state == fsqrt_load_st) begin
      res_exp_q <= EXP_W'(e_res);
      cnt_q     <= CNT_W'(N - 1);
    end else if (state == fsqrt_iter_st) begin
      cnt_q     <= cnt_q - 1'b1;
    end
  end

  assign done = (state == fsqrt_result_valid_st);
  assign busy = (state != fsqrt_idle_st);

endmodule
